// File: rtl/rom_read_arbiter_pkg.sv
// Shared arbiter types and the round-robin pick helper used by the ROM read
// arbiter and the other round-robin arbiters in the design.
package rom_read_arbiter_pkg;

    localparam int MAX_REQ   = 8;
    localparam int MAX_IDX_W = 3;

    typedef enum logic {IDLE, BURST} rom_arb_state_t;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of vld scanning ptr, ptr+1, ... modulo n (n <= MAX_REQ, ptr < n).
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]   vld,
                                         input logic [MAX_IDX_W-1:0] ptr,
                                         input int                   n);
        rr_pick_t res;
        int       j;
        res = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            j = (int'(ptr) + k) % n;
            if (k < n && !res.found && vld[MAX_IDX_W'(j)]) begin
                res.found = 1'b1;
                res.idx   = MAX_IDX_W'(j);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rom_read_arbiter_rr.sv
// Combinational round-robin winner select over a request vector.
module rr_arbiter
    import rom_read_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    rr_pick_t pick;

    assign pick  = rr_pick(MAX_REQ'(req), MAX_IDX_W'(ptr), NUM_REQ);
    assign found = pick.found;
    assign idx   = IDX_W'(pick.idx);

endmodule

// File: rtl/rom_read_arbiter.sv
// Round-robin burst arbiter sharing one combinational lookup ROM between
// NUM_REQ requesters; ROM address and returned data are both registered.
module rom_read_arbiter
    import rom_read_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 9,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [ADDR_WIDTH-1:0]           rom_addr,
    input  logic [DATA_WIDTH-1:0]           rom_data,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_data,
    output logic                            rsp_last,
    output logic                            busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    rom_arb_state_t                     state;
    logic [IDX_W-1:0]                   rr_ptr;
    logic [IDX_W-1:0]                   owner;
    logic [IDX_W-1:0]                   win;
    logic                               found;
    logic [LEN_WIDTH-1:0]               remaining;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_v;
    logic [NUM_REQ-1:0][LEN_WIDTH-1:0]  len_v;

    assign addr_v = req_addr;
    assign len_v  = req_len;
    assign busy   = (state == BURST);

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .found (found),
        .idx   (win)
    );

    // Grant is combinational so the requester sees acceptance in its request cycle.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && found)
            req_ready[win] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            remaining <= '0;
            rom_addr  <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_last  <= 1'b0;
        end else begin
            rsp_valid <= '0;
            rsp_last  <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        owner     <= win;
                        rom_addr  <= addr_v[win];
                        remaining <= len_v[win];
                        rr_ptr    <= (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                        state     <= BURST;
                    end
                end
                BURST: begin
                    rsp_data         <= rom_data;
                    rsp_valid[owner] <= 1'b1;
                    rsp_last         <= (remaining == '0);
                    if (remaining == '0) begin
                        state <= IDLE;
                    end else begin
                        // Natural overflow gives the modulo-2**ADDR_WIDTH wrap.
                        rom_addr  <= rom_addr + 1'b1;
                        remaining <= remaining - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Scoreboard bench for rom_read_arbiter: a transaction-level model predicts
// grants and burst words; a monitor checks every response the DUT presents.
module tb_rom_read_arbiter;

    localparam int N  = 4;
    localparam int AW = 4;
    localparam int DW = 9;
    localparam int LW = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*LW-1:0] req_len;
    logic [N-1:0]    req_ready;
    logic [AW-1:0]   rom_addr;
    logic [DW-1:0]   rom_data;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            rsp_last;
    logic            busy;

    rom_read_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_ready (req_ready),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] rom [16];
    initial for (int a = 0; a < 16; a++) rom[a] = DW'(a * 3 + 1);
    assign rom_data = rom[rom_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int owner; int data; bit last; } exp_t;
    exp_t sb[$];

    int nchk = 0, nerr = 0;
    bit run_mon = 0;
    int obs_g[$], obs_gc[$], obs_d[$];
    int n_rsp1 = 0;

    // Requester intentions and abstract arbiter model
    logic [N-1:0] m_valid = '0;
    int m_addr[N], m_len[N];
    int ptr = 0, free_cyc = 0, grant_cyc = -1;
    logic [N-1:0] granted = '0;

    task automatic chk(string nm, int act, int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = m_valid[i];
            req_addr[i*AW +: AW]  = AW'(m_addr[i]);
            req_len[i*LW +: LW]   = LW'(m_len[i]);
        end
    endtask

    task automatic model_step();
        logic [N-1:0] exp_rdy;
        int win;
        exp_rdy = '0;
        win = -1;
        if (rst_n && cyc >= free_cyc && m_valid != '0) begin
            for (int k = 0; k < N; k++)
                if (win < 0 && m_valid[(ptr + k) % N]) win = (ptr + k) % N;
            exp_rdy[win] = 1'b1;
            ptr       = (win + 1) % N;
            grant_cyc = cyc;
            free_cyc  = cyc + 2 + m_len[win];
            for (int w = 0; w <= m_len[win]; w++)
                sb.push_back('{cyc + 2 + w, win, ((m_addr[win] + w) % 16) * 3 + 1, w == m_len[win]});
        end
        chk("req_ready", int'(req_ready), int'(exp_rdy));
        chk("busy", int'(busy), int'(rst_n && cyc > grant_cyc && cyc < free_cyc));
        granted = exp_rdy;
    endtask

    task automatic step();
        apply();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (granted[i]) m_valid[i] = 1'b0;
    endtask

    task automatic raise(int i, int a, int l);
        m_valid[i] = 1'b1;
        m_addr[i]  = a;
        m_len[i]   = l;
    endtask

    task automatic drain();
        for (int t = 0; t < 300; t++) begin
            if (sb.size() == 0 && cyc >= free_cyc && m_valid == '0) return;
            step();
        end
        nchk++; nerr++;
        $display("FAIL drain_timeout: %0d words still expected", sb.size());
    endtask

    task automatic wait_grant(int i);
        for (int t = 0; t < 100; t++) begin
            step();
            if (granted[i]) return;
        end
        nchk++; nerr++;
        $display("FAIL grant_timeout: requester %0d never granted", i);
    endtask

    task automatic clear_obs();
        obs_g.delete(); obs_gc.delete(); obs_d.delete(); n_rsp1 = 0;
    endtask

    // Monitor: compares every presented response with the scoreboard head
    always @(negedge clk) begin
        if (rst_n && run_mon) begin
            for (int i = 0; i < N; i++)
                if (req_ready[i]) begin obs_g.push_back(i); obs_gc.push_back(cyc); end
            if (rsp_valid != '0) begin
                obs_d.push_back(int'(rsp_data));
                if (rsp_valid[1]) n_rsp1++;
                if (sb.size() == 0) begin
                    nchk++; nerr++;
                    $display("FAIL unexpected_rsp: rsp_valid=%b data=%0d, none expected (cycle %0d)",
                             rsp_valid, rsp_data, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_cycle", cyc, e.cyc);
                    chk("rsp_valid", int'(rsp_valid), 1 << e.owner);
                    chk("rsp_data", int'(rsp_data), e.data);
                    chk("rsp_last", int'(rsp_last), int'(e.last));
                end
            end else begin
                if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                    nchk++; nerr++;
                    $display("FAIL missing_rsp: no rsp_valid, expected word %0d for req %0d (cycle %0d)",
                             sb[0].data, sb[0].owner, cyc);
                    void'(sb.pop_front());
                end
                chk("rsp_last_idle", int'(rsp_last), 0);
            end
        end
    end

    int exp_rr[5]   = '{0, 1, 2, 3, 0};
    int exp_wrap[4] = '{43, 46, 1, 4};

    initial begin
        for (int i = 0; i < N; i++) begin m_addr[i] = 0; m_len[i] = 0; end
        apply();
        repeat (2) step();
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_data", int'(rsp_data), 0);
        chk("rst_busy", int'(busy), 0);
        #2 rst_n = 1'b1;
        run_mon = 1;

        // Round-robin from rr_ptr=0 with everyone requesting; req0 re-requests
        clear_obs();
        for (int i = 0; i < N; i++) raise(i, i * 2, 0);
        wait_grant(0);
        raise(0, 3, 0);
        drain();
        chk("rr_count", obs_g.size(), 5);
        for (int k = 0; k < 5; k++) chk("rr_order", (k < obs_g.size()) ? obs_g[k] : -1, exp_rr[k]);

        // Single word
        clear_obs();
        raise(0, 5, 0);
        drain();
        chk("single_data", (obs_d.size() > 0) ? obs_d[0] : -1, 16);
        chk("single_busy_after", int'(busy), 0);

        // Burst with address wrap
        clear_obs();
        raise(2, 14, 3);
        drain();
        chk("wrap_count", obs_d.size(), 4);
        for (int k = 0; k < 4; k++) chk("wrap_data", (k < obs_d.size()) ? obs_d[k] : -1, exp_wrap[k]);

        // Back-to-back: req3 accepted in the cycle req1's last word appears
        clear_obs();
        raise(1, 7, 1);
        wait_grant(1);
        raise(3, 9, 2);
        drain();
        chk("b2b_grants", obs_g.size(), 2);
        chk("b2b_gap", (obs_gc.size() > 1) ? obs_gc[1] - obs_gc[0] : -1, 3);

        // Withdrawn request while busy
        clear_obs();
        raise(0, 0, 3);
        wait_grant(0);
        step();
        raise(1, 2, 0);
        step();
        m_valid[1] = 1'b0;
        drain();
        chk("withdraw_grants", obs_g.size(), 1);
        chk("withdraw_rsp1", n_rsp1, 0);

        // Asynchronous reset after three words of an eight-word burst
        clear_obs();
        raise(0, 0, 7);
        for (int t = 0; t < 40 && obs_d.size() < 3; t++) step();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_rom_addr", int'(rom_addr), 0);
        chk("mid_rst_rsp_valid", int'(rsp_valid), 0);
        chk("mid_rst_rsp_data", int'(rsp_data), 0);
        chk("mid_rst_rsp_last", int'(rsp_last), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_req_ready", int'(req_ready), 0);
        sb.delete();
        m_valid = '0; ptr = 0; free_cyc = 0; grant_cyc = -1;
        repeat (3) begin
            step();
            chk("in_rst_rsp_valid", int'(rsp_valid), 0);
        end
        #2 rst_n = 1'b1;
        clear_obs();
        raise(2, 3, 1);
        drain();
        chk("post_rst_grant", (obs_g.size() > 0) ? obs_g[0] : -1, 2);

        // Randomized traffic
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!m_valid[i] && $urandom_range(0, 3) == 0)
                    raise(i, $urandom_range(0, 15),
                          ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2));
                else if (m_valid[i] && $urandom_range(0, 19) == 0)
                    m_valid[i] = 1'b0;
            end
            step();
        end
        m_valid = '0;
        drain();
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
